wb_stage_buf: RTL and testbench

// Parametrised writeback stage of the 5-stage MIPS pipeline. Sits between MEM
// and the register file. Adds valid/ready handshake, a DEPTH-entry result

---
 rtl/wb_stage_buf_if.sv | 38 +++
 rtl/wb_stage_buf.sv | 152 +++++++++++++++
 tb/tb_wb_stage_buf.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_buf_if.sv
// wb_stage_buf_if: MEM -> WB instruction handshake bundle.
//
// Handshake: the master (MEM stage) drives in_valid together with the payload
// and holds both stable until the cycle in which in_ready is also high. A
// transfer happens on every rising edge where in_valid & in_ready. in_ready
// never depends on in_valid.
//
// Signals
//   in_valid     master -> slave  instruction present
//   in_ready     slave  -> master stage can accept
//   in_pc        master -> slave  instruction PC
//   in_regwrite  master -> slave  instruction writes rd
//   in_ld_type   master -> slave  000 ALU,001 LB,010 LBU,011 LH,100 LHU,101 LW
//   in_aluout    master -> slave  ALU result / load address
//   in_rdata     master -> slave  data_sram_rdata aligned with in_valid
//   in_rd        master -> slave  destination register
interface wb_stage_buf_if #(
    parameter int RF_AW = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic             in_regwrite;
    logic [2:0]       in_ld_type;
    logic [31:0]      in_aluout;
    logic [31:0]      in_rdata;
    logic [RF_AW-1:0] in_rd;

    modport master (
        output in_valid, in_pc, in_regwrite, in_ld_type, in_aluout, in_rdata, in_rd,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_regwrite, in_ld_type, in_aluout, in_rdata, in_rd,
        output in_ready
    );
endinterface

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: writeback stage of the 5-stage MIPS pipeline.
//
// Accepts instructions from MEM through a valid/ready handshake, performs load
// extraction and misaligned-load detection at push time, and queues the
// resulting register-file writes in a DEPTH-entry FIFO. The queue head drives
// the register file, the debug trace port and the address-error outputs
// combinationally; it retires every cycle it is present and wb_stall is low.
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous active-low reset
//   bus             MEM-side handshake (slave modport)
//   wb_stall        hold queue head
//   rf_we/waddr/wdata  register-file write port
//   debug_wb_pc     PC of the head entry
//   debug_wb_rf_wen {4{rf_we}}
//   exc_adel        one-cycle pulse when a misaligned load retires
//   exc_badvaddr    address of the most recent misaligned load
//   retire_cnt      instructions retired since reset
module wb_stage_buf #(
    parameter int DEPTH = 2,
    parameter int RF_AW = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    wb_stage_buf_if.slave    bus,
    input  logic             wb_stall,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic             exc_adel,
    output logic [31:0]      exc_badvaddr,
    output logic [CNT_W-1:0] retire_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue storage, one array per entry field.
    logic [31:0]      q_pc    [DEPTH];
    logic             q_we    [DEPTH];
    logic [RF_AW-1:0] q_waddr [DEPTH];
    logic [31:0]      q_wdata [DEPTH];
    logic             q_adel  [DEPTH];
    logic [31:0]      q_addr  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   badvaddr_q;

    logic full;
    logic empty;
    logic show;
    logic push;
    logic pop;

    // Push-side computed entry fields.
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;
    logic        ext_adel;
    logic        ext_we;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Outputs are suppressed while reset is low so a reset that lands on a
    // non-empty queue emits nothing in its own cycle.
    assign show = reset & ~empty;
    assign pop  = show & ~wb_stall;

    // No bypass: a pop while full frees the slot only for the next cycle.
    assign bus.in_ready = reset & ~full;
    assign push         = bus.in_valid & bus.in_ready;

    always_comb begin
        lane     = bus.in_aluout[1:0];
        byte_sel = bus.in_rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? bus.in_rdata[31:16] : bus.in_rdata[15:0];
        ext_data = bus.in_aluout;
        ext_adel = 1'b0;
        case (bus.in_ld_type)
            3'b001: ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010: ext_data = {24'h0, byte_sel};
            3'b011: begin
                ext_data = {{16{half_sel[15]}}, half_sel};
                ext_adel = lane[0];
            end
            3'b100: begin
                ext_data = {16'h0, half_sel};
                ext_adel = lane[0];
            end
            3'b101: begin
                ext_data = bus.in_rdata;
                ext_adel = (lane != 2'b00);
            end
            default: ext_data = bus.in_aluout;
        endcase
        ext_we = bus.in_regwrite & (bus.in_rd != '0) & ~ext_adel;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= bus.in_pc;
            q_we[wr_ptr]    <= ext_we;
            q_waddr[wr_ptr] <= bus.in_rd;
            q_wdata[wr_ptr] <= ext_data;
            q_adel[wr_ptr]  <= ext_adel;
            q_addr[wr_ptr]  <= bus.in_aluout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
            badvaddr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (q_adel[rd_ptr]) begin
                    badvaddr_q <= q_addr[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rf_we           = pop & q_we[rd_ptr];
    assign rf_waddr        = show ? q_waddr[rd_ptr] : '0;
    assign rf_wdata        = show ? q_wdata[rd_ptr] : '0;
    assign debug_wb_pc     = show ? q_pc[rd_ptr] : '0;
    assign debug_wb_rf_wen = {4{rf_we}};
    assign exc_adel        = pop & q_adel[rd_ptr];
    // The faulting address is visible in the same cycle as the pulse and is
    // then held by the register until the next misaligned load retires.
    assign exc_badvaddr    = exc_adel ? q_addr[rd_ptr] : badvaddr_q;
endmodule

// File: tb/tb_wb_stage_buf.sv
module tb_wb_stage_buf;
    logic        clk;
    logic        reset;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic        exc_adel;
    logic [31:0] exc_badvaddr;
    logic [31:0] retire_cnt;

    int total;
    int bad;

    wb_stage_buf_if #(.RF_AW(5)) bus ();

    wb_stage_buf #(.DEPTH(2), .RF_AW(5), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .wb_stall        (wb_stall),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .debug_wb_pc     (debug_wb_pc),
        .debug_wb_rf_wen (debug_wb_rf_wen),
        .exc_adel        (exc_adel),
        .exc_badvaddr    (exc_badvaddr),
        .retire_cnt      (retire_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, outputs are checked on
    // the falling edge before new inputs are applied.
    task automatic drive_in(input logic [31:0] pc, input logic regwrite,
                            input logic [2:0] ld_type, input logic [31:0] alu,
                            input logic [31:0] rdata, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_regwrite = regwrite;
        bus.in_ld_type  = ld_type;
        bus.in_aluout   = alu;
        bus.in_rdata    = rdata;
        bus.in_rd       = rd;
    endtask

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_regwrite = 1'b0;
        bus.in_ld_type  = '0;
        bus.in_aluout   = '0;
        bus.in_rdata    = '0;
        bus.in_rd       = '0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wb_stall = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
        total++; if (exc_badvaddr !== 32'd0) begin bad++; $display("FAIL reset_badvaddr got=%h exp=0", exc_badvaddr); end
        total++; if ({debug_wb_pc, rf_wdata} !== 64'd0) begin bad++; $display("FAIL reset_outputs got=%h/%h exp=0", debug_wb_pc, rf_wdata); end
    endtask

    task automatic test_alu();
        drive_in(32'h0000_0100, 1'b1, 3'b000, 32'h0000_1234, 32'hAAAA_AAAA, 5'd8);
        @(negedge clk);
        drive_idle();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%b exp=1", rf_we); end
        total++; if (rf_waddr !== 5'd8) begin bad++; $display("FAIL alu_waddr got=%0d exp=8", rf_waddr); end
        total++; if (rf_wdata !== 32'h0000_1234) begin bad++; $display("FAIL alu_wdata got=%h exp=00001234", rf_wdata); end
        total++; if (debug_wb_rf_wen !== 4'hF) begin bad++; $display("FAIL alu_wen got=%h exp=f", debug_wb_rf_wen); end
        total++; if (debug_wb_pc !== 32'h0000_0100) begin bad++; $display("FAIL alu_pc got=%h exp=00000100", debug_wb_pc); end
        @(negedge clk);
        total++; if (retire_cnt !== 32'd1) begin bad++; $display("FAIL alu_retire got=%0d exp=1", retire_cnt); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_empty_we got=%b exp=0", rf_we); end
    endtask

    task automatic test_loads();
        logic [2:0]  types [5];
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        types = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        addrs = '{32'h0000_0103, 32'h0000_0103, 32'h0000_0102, 32'h0000_0102, 32'h0000_0100};
        exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_0000};
        // Back-to-back pushes with simultaneous pops, one result per cycle.
        for (int i = 0; i < 5; i++) begin
            drive_in(32'h200 + 32'(i * 4), 1'b1, types[i], addrs[i], 32'h80FF_0000, 5'(9 + i));
            @(negedge clk);
            total++; if (rf_we !== 1'b1 || rf_waddr !== 5'(9 + i)) begin bad++; $display("FAIL load%0d_we got=%b/%0d exp=1/%0d", i, rf_we, rf_waddr, 9 + i); end
            total++; if (rf_wdata !== exps[i]) begin bad++; $display("FAIL load%0d_wdata got=%h exp=%h", i, rf_wdata, exps[i]); end
            total++; if (exc_adel !== 1'b0) begin bad++; $display("FAIL load%0d_adel got=%b exp=0", i, exc_adel); end
        end
        drive_idle();
        @(negedge clk);
        total++; if (retire_cnt !== 32'd6) begin bad++; $display("FAIL loads_retire got=%0d exp=6", retire_cnt); end
    endtask

    task automatic test_adel();
        drive_in(32'h0000_0300, 1'b1, 3'b101, 32'h0000_1002, 32'h1234_5678, 5'd5);
        @(negedge clk);
        drive_idle();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL adel_we got=%b exp=0", rf_we); end
        total++; if (exc_adel !== 1'b1) begin bad++; $display("FAIL adel_pulse got=%b exp=1", exc_adel); end
        total++; if (exc_badvaddr !== 32'h0000_1002) begin bad++; $display("FAIL adel_addr got=%h exp=00001002", exc_badvaddr); end
        total++; if (debug_wb_pc !== 32'h0000_0300) begin bad++; $display("FAIL adel_pc got=%h exp=00000300", debug_wb_pc); end
        @(negedge clk);
        total++; if (exc_adel !== 1'b0) begin bad++; $display("FAIL adel_once got=%b exp=0", exc_adel); end
        total++; if (exc_badvaddr !== 32'h0000_1002) begin bad++; $display("FAIL adel_hold got=%h exp=00001002", exc_badvaddr); end
        total++; if (retire_cnt !== 32'd7) begin bad++; $display("FAIL adel_retire got=%0d exp=7", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        wb_stall = 1'b1;
        drive_in(32'h0000_0400, 1'b1, 3'b000, 32'h0000_0011, 32'h0, 5'd1);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1 got=%b exp=1", bus.in_ready); end
        drive_in(32'h0000_0404, 1'b1, 3'b000, 32'h0000_0022, 32'h0, 5'd2);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_full got=%b exp=0", bus.in_ready); end
        total++; if (rf_we !== 1'b0 || debug_wb_pc !== 32'h0000_0400) begin bad++; $display("FAIL stall_hold got=%b/%h exp=0/00000400", rf_we, debug_wb_pc); end
        drive_in(32'h0000_0408, 1'b1, 3'b000, 32'h0000_0033, 32'h0, 5'd3);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || rf_waddr !== 5'd1) begin bad++; $display("FAIL stall_held got=%b/%0d exp=0/1", bus.in_ready, rf_waddr); end
        wb_stall = 1'b0;
        #1;
        total++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_0011) begin bad++; $display("FAIL release_a got=%b/%h exp=1/00000011", rf_we, rf_wdata); end
        // Pop while full: the third push is still refused this cycle.
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h0000_0022) begin bad++; $display("FAIL release_b got=%b/%0d/%h exp=1/2/00000022", rf_we, rf_waddr, rf_wdata); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        drive_idle();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h0000_0033) begin bad++; $display("FAIL release_c got=%b/%0d/%h exp=1/3/00000033", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL release_empty got=%b exp=0", rf_we); end
        total++; if (retire_cnt !== 32'd10) begin bad++; $display("FAIL stall_retire got=%0d exp=10", retire_cnt); end
    endtask

    task automatic test_rd_zero();
        drive_in(32'h0000_0500, 1'b1, 3'b000, 32'h0000_DEAD, 32'h0, 5'd0);
        @(negedge clk);
        drive_idle();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
        total++; if (debug_wb_pc !== 32'h0000_0500) begin bad++; $display("FAIL rd0_pc got=%h exp=00000500", debug_wb_pc); end
        @(negedge clk);
        total++; if (retire_cnt !== 32'd11) begin bad++; $display("FAIL rd0_retire got=%0d exp=11", retire_cnt); end
    endtask

    task automatic test_mid_reset();
        wb_stall = 1'b1;
        drive_in(32'h0000_0600, 1'b1, 3'b000, 32'h0000_0066, 32'h0, 5'd6);
        @(negedge clk);
        drive_in(32'h0000_0604, 1'b1, 3'b101, 32'h0000_0003, 32'h0, 5'd7);
        @(negedge clk);
        drive_idle();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mrst_full got=%b exp=0", bus.in_ready); end
        wb_stall = 1'b0;
        reset    = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || exc_adel !== 1'b0) begin bad++; $display("FAIL mrst_cycle got=%b/%b exp=0/0", rf_we, exc_adel); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || exc_adel !== 1'b0) begin bad++; $display("FAIL mrst_after got=%b/%b exp=0/0", rf_we, exc_adel); end
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL mrst_retire got=%0d exp=0", retire_cnt); end
        total++; if (bus.in_ready !== 1'b1 || debug_wb_pc !== 32'd0) begin bad++; $display("FAIL mrst_empty got=%b/%h exp=1/0", bus.in_ready, debug_wb_pc); end
        @(negedge clk);
        total++; if (rf_we !== 1'b0 || exc_badvaddr !== 32'd0) begin bad++; $display("FAIL mrst_quiet got=%b/%h exp=0/0", rf_we, exc_badvaddr); end
        drive_in(32'h0000_0700, 1'b1, 3'b000, 32'h0000_0077, 32'h0, 5'd7);
        @(negedge clk);
        drive_idle();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_0077) begin bad++; $display("FAIL mrst_resume got=%b/%0d/%h exp=1/7/00000077", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        total++; if (retire_cnt !== 32'd1) begin bad++; $display("FAIL mrst_recount got=%0d exp=1", retire_cnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu();
        test_loads();
        test_adel();
        test_back_to_back();
        test_rd_zero();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
